universal_shift_register: RTL and testbench



---
 rtl/universal_shift_register.sv | 91 +++++++++
 tb/tb_universal_shift_register.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/universal_shift_register.sv
// N-bit universal shift register: parallel load, four shift modes, and a
// counted-burst sequencer (IDLE/RUN) that runs up to N shifts and pulses done.
module universal_shift_register #(
  parameter  int N  = 8,
  localparam int CW = $clog2(N+1)
) (
  input  logic          clk,
  input  logic          clear,
  input  logic          load,
  input  logic [N-1:0]  in,
  input  logic [1:0]    mode,
  input  logic          serial_in,
  input  logic          shift,
  input  logic          start,
  input  logic [CW-1:0] steps,
  output logic [N-1:0]  out,
  output logic          shifted_bit,
  output logic          busy,
  output logic          done
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state;
  logic [1:0]    burst_mode;
  logic [CW-1:0] count;

  // Returns {shifted_bit, out} after one step; mode 00 keeps both as they are.
  function automatic logic [N:0] shift_step(input logic [1:0] m, input logic [N-1:0] v,
                                            input logic si, input logic sb);
    logic [N:0] r;
    case (m)
      2'b01:   r = {v[0], v[N-1], v[N-1:1]};
      2'b10:   r = {v[0], si, v[N-1:1]};
      2'b11:   r = {v[N-1], v[N-2:0], si};
      default: r = {sb, v};
    endcase
    return r;
  endfunction

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state       <= IDLE;
      out         <= '0;
      shifted_bit <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      count       <= '0;
      burst_mode  <= 2'b00;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (load) begin
            out <= in;
          end else if (start) begin
            burst_mode <= mode;
            count      <= (steps > CW'(N)) ? CW'(N) : steps;
            busy       <= 1'b1;
            state      <= RUN;
          end else if (shift) begin
            {shifted_bit, out} <= shift_step(mode, out, serial_in, shifted_bit);
          end
        end
        RUN: begin
          if (load) begin
            // Abort: take the new operand and drop back without signalling completion.
            out   <= in;
            count <= '0;
            busy  <= 1'b0;
            state <= IDLE;
          end else if (count != '0) begin
            {shifted_bit, out} <= shift_step(burst_mode, out, serial_in, shifted_bit);
            count <= count - 1'b1;
            if (count == CW'(1)) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= IDLE;
            end
          end else begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_universal_shift_register.sv
// Directed bench for universal_shift_register (N=8): load, single shifts,
// bursts in each mode, saturation, zero-step burst, abort and async clear.
module tb_universal_shift_register;
  localparam int N  = 8;
  localparam int CW = $clog2(N+1);

  logic          clk = 1'b0;
  logic          clear;
  logic          load;
  logic [N-1:0]  in;
  logic [1:0]    mode;
  logic          serial_in;
  logic          shift;
  logic          start;
  logic [CW-1:0] steps;
  logic [N-1:0]  out;
  logic          shifted_bit;
  logic          busy;
  logic          done;

  int total = 0;
  int bad   = 0;

  universal_shift_register #(.N(N)) dut (
    .clk(clk), .clear(clear), .load(load), .in(in), .mode(mode),
    .serial_in(serial_in), .shift(shift), .start(start), .steps(steps),
    .out(out), .shifted_bit(shifted_bit), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [N-1:0] v);
    load = 1'b1; in = v;
    step();
    load = 1'b0;
  endtask

  initial begin
    clear = 1'b1; load = 1'b0; in = '0; mode = 2'b00; serial_in = 1'b0;
    shift = 1'b0; start = 1'b0; steps = '0;
    step();
    check("rst_out", out, 0);
    check("rst_sb", shifted_bit, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    clear = 1'b0;

    // Single arithmetic shift right
    do_load(8'hB4);
    check("load_b4", out, 8'hB4);
    mode = 2'b01; shift = 1'b1;
    step();
    shift = 1'b0;
    check("single_out", out, 8'hDA);
    check("single_sb", shifted_bit, 0);
    check("single_busy", busy, 0);

    // ASR burst of 3; mode input changed mid-burst must be ignored
    do_load(8'h96);
    mode = 2'b01; steps = 4'd3; start = 1'b1;
    step();
    start = 1'b0; mode = 2'b11;
    check("asr_busy_k", busy, 1);
    check("asr_out_k", out, 8'h96);
    step();
    check("asr_out_k1", out, 8'hCB);
    check("asr_sb_k1", shifted_bit, 0);
    step();
    check("asr_out_k2", out, 8'hE5);
    check("asr_done_k2", done, 0);
    step();
    check("asr_out_k3", out, 8'hF2);
    check("asr_sb_k3", shifted_bit, 1);
    check("asr_done_k3", done, 1);
    check("asr_busy_k3", busy, 0);
    step();
    check("asr_done_k4", done, 0);

    // Shift-left burst of 2
    do_load(8'h81);
    serial_in = 1'b1; mode = 2'b11; steps = 4'd2; start = 1'b1;
    step();
    start = 1'b0;
    step();
    check("shl_out_k1", out, 8'h03);
    check("shl_done_k1", done, 0);
    step();
    check("shl_out_k2", out, 8'h07);
    check("shl_sb_k2", shifted_bit, 0);
    check("shl_done_k2", done, 1);

    // Saturation: steps=12 runs exactly 8 logical shifts
    do_load(8'hFF);
    serial_in = 1'b0; mode = 2'b10; steps = 4'd12; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 1; i <= 7; i++) step();
    check("sat_out_k7", out, 8'h01);
    check("sat_done_k7", done, 0);
    check("sat_busy_k7", busy, 1);
    step();
    check("sat_out_k8", out, 8'h00);
    check("sat_sb_k8", shifted_bit, 1);
    check("sat_done_k8", done, 1);

    // Zero-step burst started during the done pulse
    steps = 4'd0; start = 1'b1;
    step();
    start = 1'b0;
    check("zero_busy_k", busy, 1);
    check("zero_done_k", done, 0);
    step();
    check("zero_busy_k1", busy, 0);
    check("zero_done_k1", done, 1);
    check("zero_out_k1", out, 8'h00);

    // Ignore start/shift/mode during a burst, then abort with load
    do_load(8'h5A);
    mode = 2'b01; steps = 4'd5; start = 1'b1;
    step();
    mode = 2'b11; shift = 1'b1;
    step();
    start = 1'b0; shift = 1'b0;
    check("ign_out_1", out, 8'h2D);
    check("ign_busy_1", busy, 1);
    step();
    check("ign_out_2", out, 8'h16);
    load = 1'b1; in = 8'h3C;
    step();
    load = 1'b0;
    check("abort_out", out, 8'h3C);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    step();
    check("abort_done_n", done, 0);
    check("abort_out_n", out, 8'h3C);

    // Load beats start in IDLE
    load = 1'b1; start = 1'b1; in = 8'hA5; steps = 4'd4;
    step();
    load = 1'b0; start = 1'b0;
    check("ldst_out", out, 8'hA5);
    check("ldst_busy", busy, 0);
    step();
    check("ldst_out_n", out, 8'hA5);
    check("ldst_done_n", done, 0);

    // Async clear mid-burst
    do_load(8'hFF);
    mode = 2'b10; serial_in = 1'b0; steps = 4'd8; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 1; i <= 3; i++) step();
    check("clr_pre_out", out, 8'h1F);
    #1 clear = 1'b1;
    #1;
    check("clr_out", out, 8'h00);
    check("clr_busy", busy, 0);
    check("clr_done", done, 0);
    check("clr_sb", shifted_bit, 0);
    step();
    clear = 1'b0;
    step();
    check("clr_post_busy", busy, 0);
    check("clr_post_done", done, 0);
    check("clr_post_out", out, 8'h00);
    step();
    check("clr_post_out2", out, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
